// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding and byte width.
package uart_pkg;

    localparam int UART_DW = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART TX FIFO signals shared between the arbiter (slave) and its environment (master).
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0]         req_valid;
    logic [UART_DW*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]         req_last;
    logic [N_REQ-1:0]         req_ready;
    logic                     tx_full;
    logic                     wr_uart;
    logic [UART_DW-1:0]       w_data;
    logic [N_REQ-1:0]         grant;
    logic                     busy;

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, wr_uart, w_data, grant, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, wr_uart, w_data, grant, busy
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or above i_ptr, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_winner,
    output logic             o_found
);

    // Rank each requester by its wrapped distance from the pointer; the smallest rank wins.
    always_comb begin
        int d;
        int best;
        d        = 0;
        best     = N_REQ;
        o_winner = '0;
        o_found  = |i_req;
        for (int i = 0; i < N_REQ; i++) begin
            d = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + N_REQ - int'(i_ptr));
            if (i_req[i] && d < best) begin
                best = d;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            d = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + N_REQ - int'(i_ptr));
            if (i_req[i] && d == best) begin
                o_winner[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port among N_REQ byte-stream requesters.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   bus
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             r_state, w_next_state;
    logic [N_REQ-1:0]   r_grant, w_next_grant;
    logic [PW-1:0]      r_ptr, w_next_ptr, w_inc_ptr;
    logic [7:0]         r_byte_cnt, w_next_byte_cnt, w_byte_inc;
    logic [7:0]         r_idle_cnt, w_next_idle_cnt, w_idle_inc;
    logic               r_wr_uart, w_next_wr_uart;
    logic [UART_DW-1:0] r_w_data, w_next_w_data, w_sel_data;
    logic [N_REQ-1:0]   w_winner, w_ready;
    logic               w_found, w_sel_valid, w_sel_last, w_accept, w_release;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .i_req    (bus.req_valid),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

    // Blocking ready for one cycle after each write lets tx_full catch up with that write.
    assign w_ready     = (r_state == GRANT && !bus.tx_full && !r_wr_uart) ? r_grant : '0;
    assign w_sel_valid = |(bus.req_valid & r_grant);
    assign w_sel_last  = |(bus.req_last & r_grant);
    assign w_accept    = |(bus.req_valid & w_ready);
    assign w_byte_inc  = r_byte_cnt + 8'd1;
    assign w_idle_inc  = r_idle_cnt + 8'd1;

    always_comb begin
        w_sel_data = '0;
        w_inc_ptr  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_sel_data = bus.req_data[i*UART_DW +: UART_DW];
                w_inc_ptr  = PW'((i + 1) % N_REQ);
            end
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_grant    = r_grant;
        w_next_ptr      = r_ptr;
        w_next_byte_cnt = r_byte_cnt;
        w_next_idle_cnt = r_idle_cnt;
        w_next_wr_uart  = 1'b0;
        w_next_w_data   = r_w_data;
        w_release       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_state    = GRANT;
                    w_next_grant    = w_winner;
                    w_next_byte_cnt = '0;
                    w_next_idle_cnt = '0;
                end
            end
            GRANT: begin
                if (w_accept) begin
                    w_next_wr_uart  = 1'b1;
                    w_next_w_data   = w_sel_data;
                    w_next_byte_cnt = w_byte_inc;
                    w_next_idle_cnt = '0;
                    w_release       = w_sel_last || (w_byte_inc == 8'(MAX_BURST));
                end else if (!w_sel_valid) begin
                    w_next_idle_cnt = w_idle_inc;
                    w_release       = (w_idle_inc == 8'(IDLE_TIMEOUT));
                end
                if (w_release) begin
                    w_next_state = IDLE;
                    w_next_grant = '0;
                    w_next_ptr   = w_inc_ptr;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_byte_cnt <= '0;
            r_idle_cnt <= '0;
            r_wr_uart  <= 1'b0;
            r_w_data   <= '0;
        end else begin
            r_state    <= w_next_state;
            r_grant    <= w_next_grant;
            r_ptr      <= w_next_ptr;
            r_byte_cnt <= w_next_byte_cnt;
            r_idle_cnt <= w_next_idle_cnt;
            r_wr_uart  <= w_next_wr_uart;
            r_w_data   <= w_next_w_data;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.wr_uart   = r_wr_uart;
    assign bus.w_data    = r_w_data;
    assign bus.grant     = r_grant;
    assign bus.busy      = (r_state == GRANT);

endmodule
